// File: rtl/bwt_occ_responder.sv
// bwt_occ_responder: buffers occurrence-table requests and fetches the k/l BWT lines from memory.
// Optional SAME_LINE_SHARE_EN: an equal k/l address issues one read that fills both count sets.
module bwt_occ_responder #(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BWT_BASE   = 32'h0000_0000
) (
  input  logic         Clk_32UI,
  input  logic         reset_BWT_extend,
  input  logic         DRAM_valid,
  input  logic [31:0]  addr_k,
  input  logic [31:0]  addr_l,
  output logic         mem_req_valid,
  input  logic         mem_req_ready,
  output logic [31:0]  mem_req_addr,
  input  logic         mem_rsp_valid,
  input  logic [511:0] mem_rsp_data,
  output logic         DRAM_get,
  output logic [31:0]  cnt_a0,
  output logic [31:0]  cnt_a1,
  output logic [31:0]  cnt_a2,
  output logic [31:0]  cnt_a3,
  output logic [63:0]  cnt_b0,
  output logic [63:0]  cnt_b1,
  output logic [63:0]  cnt_b2,
  output logic [63:0]  cnt_b3,
  output logic [31:0]  cntl_a0,
  output logic [31:0]  cntl_a1,
  output logic [31:0]  cntl_a2,
  output logic [31:0]  cntl_a3,
  output logic [63:0]  cntl_b0,
  output logic [63:0]  cntl_b1,
  output logic [63:0]  cntl_b2,
  output logic [63:0]  cntl_b3,
  output logic         fifo_overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [2:0] {IDLE, REQ_K, REQ_L, WAIT_K, WAIT_L, RESP} state_t;
  state_t r_state, w_next;
  logic [63:0]   r_fifo [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_k, r_l;
  logic          r_kgot;
  logic [31:0]   r_ka [4];
  logic [63:0]   r_kb [4];
  logic [31:0]   r_la [4];
  logic [63:0]   r_lb [4];
  logic          w_empty, w_full, w_pop, w_push, w_same, w_lat_k, w_lat_l;
  logic          w_unused;
  assign w_unused = &{1'b0, mem_rsp_data[511:384]};
`ifdef SAME_LINE_SHARE_EN
  assign w_same = (r_k == r_l);
`else
  assign w_same = 1'b0;
`endif
  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(FIFO_DEPTH));
  assign w_pop   = (r_state == IDLE) && !w_empty;
  assign w_push  = DRAM_valid && (!w_full || w_pop);
  // The k line may come back while the l request is still waiting for ready.
  assign w_lat_k = mem_rsp_valid && ((r_state == WAIT_K) || (r_state == REQ_L && !r_kgot));
  assign w_lat_l = mem_rsp_valid && ((r_state == WAIT_L) || (r_state == WAIT_K && w_same));
  assign mem_req_valid = (r_state == REQ_K) || (r_state == REQ_L);
  assign mem_req_addr  = BWT_BASE + ((r_state == REQ_L) ? r_l : r_k);
  assign DRAM_get      = (r_state == RESP);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_empty ? IDLE : REQ_K;
      REQ_K:   w_next = !mem_req_ready ? REQ_K : (w_same ? WAIT_K : REQ_L);
      REQ_L:   w_next = !mem_req_ready ? REQ_L : ((r_kgot || w_lat_k) ? WAIT_L : WAIT_K);
      WAIT_K:  w_next = !mem_rsp_valid ? WAIT_K : (w_same ? RESP : WAIT_L);
      WAIT_L:  w_next = mem_rsp_valid ? RESP : WAIT_L;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge Clk_32UI) begin
    if (w_push) r_fifo[r_wp] <= {addr_k, addr_l};
  end
  always_ff @(posedge Clk_32UI or posedge reset_BWT_extend) begin
    if (reset_BWT_extend) begin
      r_state       <= IDLE;
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
      r_k           <= '0;
      r_l           <= '0;
      r_kgot        <= 1'b0;
      fifo_overflow <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_ka[i] <= '0;
        r_kb[i] <= '0;
        r_la[i] <= '0;
        r_lb[i] <= '0;
      end
    end else begin
      r_state <= w_next;
      r_cnt   <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wp <= r_wp + 1'b1;
      if (DRAM_valid && !w_push) fifo_overflow <= 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_k    <= r_fifo[r_rp][63:32];
        r_l    <= r_fifo[r_rp][31:0];
        r_kgot <= 1'b0;
      end
      if (r_state == REQ_L && w_lat_k) r_kgot <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (w_lat_k) begin
          r_ka[i] <= mem_rsp_data[32*i +: 32];
          r_kb[i] <= mem_rsp_data[128+64*i +: 64];
        end
        if (w_lat_l) begin
          r_la[i] <= mem_rsp_data[32*i +: 32];
          r_lb[i] <= mem_rsp_data[128+64*i +: 64];
        end
      end
    end
  end
  assign cnt_a0  = r_ka[0];
  assign cnt_a1  = r_ka[1];
  assign cnt_a2  = r_ka[2];
  assign cnt_a3  = r_ka[3];
  assign cnt_b0  = r_kb[0];
  assign cnt_b1  = r_kb[1];
  assign cnt_b2  = r_kb[2];
  assign cnt_b3  = r_kb[3];
  assign cntl_a0 = r_la[0];
  assign cntl_a1 = r_la[1];
  assign cntl_a2 = r_la[2];
  assign cntl_a3 = r_la[3];
  assign cntl_b0 = r_lb[0];
  assign cntl_b1 = r_lb[1];
  assign cntl_b2 = r_lb[2];
  assign cntl_b3 = r_lb[3];
endmodule
